pipeline_ctrl: RTL
==================

# pipeline_ctrl

Central stall/flush sequencer for the 5-stage ARM pipeline. It combines the hazard detector's `Hazard` output, the EXE-stage branch-taken signal and the SRAM controller's ready handshake into per-stage freeze/flush controls. It also runs a post-reset pipeline hold, a memory-wait watchdog and saturating performance counters. It sits beside the hazard detection unit and drives the PC, IF/ID, ID/EX, EXE/MEM and MEM/WB register enables and clears.

## Interface
- `INIT_CYCLES`, 4: cycles the pipeline is held frozen after reset; must be ≥1.
- `MEM_TIMEOUT`, 64: consecutive memory-frozen cycles before the error state; must be ≥2.
- `CNT_W`, 16: performance counter width.

- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `hazard`  in  1  from hazard detection; ID-stage instruction must wait.
- `branch_taken`  in  1  EXE-stage branch resolved taken.
- `mem_req`  in  1  MEM stage holds a load/store.
- `mem_ready`  in  1  SRAM controller completes the current access this cycle.
- `clr_counters`  in  1  synchronous clear of the three performance counters.
- `freeze_if`  out  1  hold PC and IF/ID.
- `flush_if_id`  out  1  load NOP into IF/ID.
- `bubble_id_ex`  out  1  load NOP into ID/EX.
- `freeze_all`  out  1  hold ID/EX, EXE/MEM, MEM/WB.
- `mem_timeout`  out  1  sticky watchdog error.
- `state`  out  2  current FSM state.
- `stall_cnt`  out  CNT_W  hazard stall cycles.
- `flush_cnt`  out  CNT_W  branch flush events.
- `memwait_cnt`  out  CNT_W  memory-frozen cycles.

## Operation
- FSM states: INIT=2'b00, RUN=2'b01, MEM_WAIT=2'b10, ERR=2'b11. Control outputs are combinational from the state and the inputs. State and counters are registered.
- **INIT**
  - Outputs: `freeze_if`=`freeze_all`=1, flushes 0.
  - The init counter increments each cycle. After `INIT_CYCLES` cycles, the next state is RUN.
- **RUN**, strict priority, first match wins:
  1. `mem_req`&&!`mem_ready`: `freeze_if`=`freeze_all`=1, flushes 0. Next state MEM_WAIT. `wait_cnt`<=1. `memwait_cnt`++.
  2. `branch_taken`: `flush_if_id`=`bubble_id_ex`=1, `freeze_if`=0. `flush_cnt`++.
  3. `hazard`: `freeze_if`=`bubble_id_ex`=1. `stall_cnt`++.
  4. Otherwise: all controls 0.
- **MEM_WAIT**
  - If `mem_ready`=0: freeze as in RUN case 1, `memwait_cnt`++ and `wait_cnt`++. If `wait_cnt`+1==`MEM_TIMEOUT`, the next state is ERR.
  - If `mem_ready`=1: RUN cases 2–4 are evaluated this cycle (`mem_req` is ignored) and the next state is RUN. `wait_cnt`<=0.
- **ERR**
  - Outputs: `freeze_if`=`freeze_all`=1, `mem_timeout`=1, flushes 0.
  - Counters hold. Only `rst` exits this state.
- Counter rules:
  - All counters saturate at 2^CNT_W−1.
  - `clr_counters` beats an increment in the same cycle; the result is 0.
  - Counters update only in RUN and MEM_WAIT.
- `flush_if_id`/`bubble_id_ex` never assert while `freeze_all`=1.
- A branch and a hazard together count as a flush only.

## Timing
- Reset values: `state`=INIT, all counters 0, `mem_timeout`=0, init/`wait_cnt` 0. While `rst`=1: `freeze_if`=`freeze_all`=1 and flushes 0.
- After `rst` falls, `state`=RUN from rising edge `INIT_CYCLES` onward.
- Flush and stall controls have zero-cycle latency: same cycle as `branch_taken`/`hazard`.
- Memory handshake:
  - Freeze holds for every cycle that `mem_ready`=0.
  - The cycle with `mem_ready`=1 is unfrozen. There is no extra bubble after release.
- Watchdog: with `mem_ready` held 0 from RUN cycle t, cycles t..t+MEM_TIMEOUT−1 are frozen and `state`=ERR from cycle t+MEM_TIMEOUT. A `mem_ready` pulse in cycle t+MEM_TIMEOUT−1 avoids ERR.
- Reset asserted mid-MEM_WAIT or in ERR returns to INIT immediately, asynchronously.

## Test plan
- Reset release, INIT_CYCLES=4 → freeze outputs 1 for 4 cycles, `state`=01 on cycle 4, all counters 0.
- RUN, `hazard`=1 for 2 cycles → `freeze_if`=`bubble_id_ex`=1 both cycles, `stall_cnt`=2, `flush_cnt`=0.
- `branch_taken`=`hazard`=1 in one cycle → `flush_if_id`=`bubble_id_ex`=1, `freeze_if`=0, `flush_cnt`=1, `stall_cnt` unchanged.
- `mem_req`=1, `mem_ready` low 3 cycles then high with `branch_taken`=1 → 3 frozen cycles with no flush, then a flush cycle, `memwait_cnt`=3, `state` back to 01.
- MEM_TIMEOUT=64, `mem_ready` stuck 0 → ERR after 64 frozen cycles, `mem_timeout`=1, counters stop at `memwait_cnt`=64. `rst` then returns `state`=00 and `mem_timeout`=0.
- CNT_W=4, 20 hazard cycles → `stall_cnt` saturates at 15. `clr_counters` asserted with `hazard`=1 gives 0.

Source files
------------

// File: rtl/pipeline_ctrl_if.sv
// Control bundle between the pipeline stall/flush sequencer and the pipeline datapath.
// The master side drives the hazard/branch/memory inputs; the slave side is the sequencer.
interface pipeline_ctrl_if #(
  parameter int unsigned CNT_W = 16
);
  logic             hazard;
  logic             branch_taken;
  logic             mem_req;
  logic             mem_ready;
  logic             clr_counters;
  logic             freeze_if;
  logic             flush_if_id;
  logic             bubble_id_ex;
  logic             freeze_all;
  logic             mem_timeout;
  logic [1:0]       state;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;
  logic [CNT_W-1:0] memwait_cnt;

  modport master (
    output hazard, branch_taken, mem_req, mem_ready, clr_counters,
    input  freeze_if, flush_if_id, bubble_id_ex, freeze_all, mem_timeout,
    input  state, stall_cnt, flush_cnt, memwait_cnt
  );

  modport slave (
    input  hazard, branch_taken, mem_req, mem_ready, clr_counters,
    output freeze_if, flush_if_id, bubble_id_ex, freeze_all, mem_timeout,
    output state, stall_cnt, flush_cnt, memwait_cnt
  );
endinterface

// File: rtl/pipeline_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: post-reset hold, hazard stalls,
// branch flushes, memory-wait freeze with watchdog, and saturating perf counters.
module pipeline_ctrl #(
  parameter int unsigned INIT_CYCLES = 4,
  parameter int unsigned MEM_TIMEOUT = 64,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  pipeline_ctrl_if.slave   bus
);

  typedef enum logic [1:0] {
    S_INIT     = 2'b00,
    S_RUN      = 2'b01,
    S_MEM_WAIT = 2'b10,
    S_ERR      = 2'b11
  } state_e;

  localparam int unsigned INIT_W = (INIT_CYCLES < 2) ? 1 : $clog2(INIT_CYCLES);
  localparam int unsigned WAIT_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [INIT_W-1:0] INIT_LAST = INIT_W'(INIT_CYCLES - 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

  state_e             state_q, state_d;
  logic [INIT_W-1:0]  init_cnt_q, init_cnt_d;
  logic [WAIT_W-1:0]  wait_cnt_q, wait_cnt_d;
  logic               mem_timeout_q, mem_timeout_d;
  logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0]   flush_cnt_q, flush_cnt_d;
  logic [CNT_W-1:0]   memwait_cnt_q, memwait_cnt_d;

  logic freeze_if, flush_if_id, bubble_id_ex, freeze_all;
  logic run_eval, cnt_en, inc_stall, inc_flush, inc_mem;

  function automatic logic [CNT_W-1:0] cnt_next(input logic [CNT_W-1:0] c,
                                                input logic inc, input logic clr);
    if (clr)
      return '0;
    if (inc && (c != '1))
      return c + CNT_W'(1);
    return c;
  endfunction

  always_comb begin
    state_d       = state_q;
    init_cnt_d    = init_cnt_q;
    wait_cnt_d    = wait_cnt_q;
    mem_timeout_d = mem_timeout_q;
    freeze_if     = 1'b0;
    flush_if_id   = 1'b0;
    bubble_id_ex  = 1'b0;
    freeze_all    = 1'b0;
    run_eval      = 1'b0;
    cnt_en        = 1'b0;
    inc_stall     = 1'b0;
    inc_flush     = 1'b0;
    inc_mem       = 1'b0;

    case (state_q)
      S_INIT: begin
        freeze_if  = 1'b1;
        freeze_all = 1'b1;
        if (init_cnt_q == INIT_LAST) begin
          state_d    = S_RUN;
          init_cnt_d = '0;
        end else begin
          init_cnt_d = init_cnt_q + INIT_W'(1);
        end
      end
      S_RUN: begin
        cnt_en = 1'b1;
        if (bus.mem_req && !bus.mem_ready) begin
          freeze_if  = 1'b1;
          freeze_all = 1'b1;
          inc_mem    = 1'b1;
          wait_cnt_d = WAIT_W'(1);
          state_d    = S_MEM_WAIT;
        end else begin
          run_eval = 1'b1;
        end
      end
      S_MEM_WAIT: begin
        cnt_en = 1'b1;
        if (!bus.mem_ready) begin
          freeze_if  = 1'b1;
          freeze_all = 1'b1;
          inc_mem    = 1'b1;
          wait_cnt_d = wait_cnt_q + WAIT_W'(1);
          // wait_cnt_q + 1 == MEM_TIMEOUT, compared against a constant to avoid widening
          if (wait_cnt_q == WAIT_LAST) begin
            state_d       = S_ERR;
            mem_timeout_d = 1'b1;
          end
        end else begin
          run_eval   = 1'b1;
          wait_cnt_d = '0;
          state_d    = S_RUN;
        end
      end
      default: begin
        freeze_if  = 1'b1;
        freeze_all = 1'b1;
      end
    endcase

    // Branch outranks hazard: the stalled ID instruction is flushed anyway.
    if (run_eval) begin
      if (bus.branch_taken) begin
        flush_if_id  = 1'b1;
        bubble_id_ex = 1'b1;
        inc_flush    = 1'b1;
      end else if (bus.hazard) begin
        freeze_if    = 1'b1;
        bubble_id_ex = 1'b1;
        inc_stall    = 1'b1;
      end
    end

    stall_cnt_d   = cnt_en ? cnt_next(stall_cnt_q,   inc_stall, bus.clr_counters) : stall_cnt_q;
    flush_cnt_d   = cnt_en ? cnt_next(flush_cnt_q,   inc_flush, bus.clr_counters) : flush_cnt_q;
    memwait_cnt_d = cnt_en ? cnt_next(memwait_cnt_q, inc_mem,   bus.clr_counters) : memwait_cnt_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_INIT;
      init_cnt_q    <= '0;
      wait_cnt_q    <= '0;
      mem_timeout_q <= 1'b0;
      stall_cnt_q   <= '0;
      flush_cnt_q   <= '0;
      memwait_cnt_q <= '0;
    end else begin
      state_q       <= state_d;
      init_cnt_q    <= init_cnt_d;
      wait_cnt_q    <= wait_cnt_d;
      mem_timeout_q <= mem_timeout_d;
      stall_cnt_q   <= stall_cnt_d;
      flush_cnt_q   <= flush_cnt_d;
      memwait_cnt_q <= memwait_cnt_d;
    end
  end

  assign bus.freeze_if    = freeze_if;
  assign bus.flush_if_id  = flush_if_id;
  assign bus.bubble_id_ex = bubble_id_ex;
  assign bus.freeze_all   = freeze_all;
  assign bus.mem_timeout  = mem_timeout_q;
  assign bus.state        = state_q;
  assign bus.stall_cnt    = stall_cnt_q;
  assign bus.flush_cnt    = flush_cnt_q;
  assign bus.memwait_cnt  = memwait_cnt_q;

endmodule
